// File: rtl/mux41_rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter in front of the 4:1 mux.
package mux41_rr_arbiter_pkg;

    localparam int unsigned SEL_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] SRC_A = 2'd0;
    localparam logic [SEL_W-1:0] SRC_B = 2'd1;
    localparam logic [SEL_W-1:0] SRC_C = 2'd2;
    localparam logic [SEL_W-1:0] SRC_D = 2'd3;

    // One-hot grant vector for a source index.
    function automatic logic [3:0] onehot4(input logic [SEL_W-1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux41_rr_arbiter_rr_pick4.sv
// Rotating-priority picker: first set request at or after ptr, wrapping 3->0.
module rr_pick4
    import mux41_rr_arbiter_pkg::*;
(
    input  logic [3:0]       req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] winner,
    output logic             any
);

    logic [SEL_W-1:0] idx;

    // Scan the four positions starting at ptr; the first request found wins.
    always_comb begin
        winner = SRC_A;
        any    = 1'b0;
        idx    = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!any && req[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter driving the select pins of a shared 4:1 mux.
// Each tenure is bounded to MAX_HOLD cycles; handoffs are back-to-back.
module mux41_rr_arbiter
    import mux41_rr_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] REQ,
    output logic [3:0] GNT,
    output logic       S1,
    output logic       S0,
    output logic       BUSY
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state, state_nxt;
    logic [SEL_W-1:0] ptr, ptr_nxt;
    logic [SEL_W-1:0] own, own_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       gnt_nxt;
    logic             busy_nxt;
    logic             release_now;
    logic [SEL_W-1:0] pick_ptr;
    logic [SEL_W-1:0] pick_win;
    logic             pick_any;

    // The select register doubles as the owner index, so S1/S0 keep the
    // last owner after the arbiter goes idle.
    assign S1 = own[1];
    assign S0 = own[0];

    assign release_now = !REQ[own] || (cnt == CNT_LAST);

    // On release the search starts one past the owner, which puts the owner
    // last: it only wins again when it is the sole requester, which is the
    // same result as masking its bit and falling back to the full vector.
    assign pick_ptr = (state == ST_GRANT) ? own + 2'd1 : ptr;

    rr_pick4 u_pick (
        .req    (REQ),
        .ptr    (pick_ptr),
        .winner (pick_win),
        .any    (pick_any)
    );

    // Next-state, pointer, tenure counter and output decisions.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        own_nxt   = own;
        cnt_nxt   = cnt;
        gnt_nxt   = GNT;
        busy_nxt  = BUSY;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_nxt = ST_GRANT;
                    own_nxt   = pick_win;
                    gnt_nxt   = onehot4(pick_win);
                    busy_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end
            end
            ST_GRANT: begin
                if (!release_now) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end else begin
                    ptr_nxt = own + 2'd1;
                    cnt_nxt = '0;
                    if (pick_any) begin
                        own_nxt = pick_win;
                        gnt_nxt = onehot4(pick_win);
                    end else begin
                        state_nxt = ST_IDLE;
                        gnt_nxt   = '0;
                        busy_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                gnt_nxt   = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            ptr   <= '0;
            own   <= '0;
            cnt   <= '0;
            GNT   <= '0;
            BUSY  <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            own   <= own_nxt;
            cnt   <= cnt_nxt;
            GNT   <= gnt_nxt;
            BUSY  <= busy_nxt;
        end
    end

endmodule
